// File: rtl/mul8_pkg.sv
// Shared definitions for the mul8 arbiter: FSM encoding, default sizing and a
// one-hot helper used to build the per-requester completion pulse.
package mul8_pkg;

  localparam int NREQ_DEF    = 4;
  localparam int TIMEOUT_DEF = 31;
  localparam int CNT_W       = 5;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_WAIT_HI = 3'd2,
    ST_WAIT_LO = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  // One-hot decode of a 2-bit requester index.
  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Four-way round-robin picker: scans req starting at ptr and wrapping, and
// reports the first requester found.
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] grant,
  output logic       valid
);

  logic [1:0] idx;

  // Scan from the farthest offset down so the nearest-to-ptr requester wins.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path leaves a value unassigned and no latch is inferred.
    grant = '0;
    valid = 1'b0;
    idx   = '0;
    for (int off = 3; off >= 0; off--) begin
      idx = ptr + 2'(off);
      if (req[idx]) begin
        grant = idx;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mul8_arb.sv
// Arbiter sharing one external mul8_loop multiplier between four requesters.
// Picks a requester round-robin, launches the multiply, waits for the busy
// handshake (with a timeout) and returns the upper product byte.
module mul8_arb
  import mul8_pkg::*;
#(
  parameter int NREQ    = NREQ_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_i,
  input  logic [8*NREQ-1:0] a_i,
  input  logic [8*NREQ-1:0] b_i,
  output logic [NREQ-1:0]   done_o,
  output logic [7:0]        p_o,
  output logic              err_o,
  output logic              mul_start_o,
  output logic [7:0]        mul_a_o,
  output logic [7:0]        mul_b_o,
  input  logic              mul_busy_i,
  input  logic [7:0]        mul_p_i
);

  state_e            state_q, state_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [1:0]        grant_q, grant_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic [7:0]        p_q, p_d;
  logic              err_q, err_d;
  logic              mul_start_q, mul_start_d;
  logic [7:0]        mul_a_q, mul_a_d;
  logic [7:0]        mul_b_q, mul_b_d;

  logic [1:0]        pick_grant;
  logic              pick_valid;
  logic              timed_out;

  rr_pick4 u_pick (
    .req   (req_i),
    .ptr   (ptr_q),
    .grant (pick_grant),
    .valid (pick_valid)
  );

  assign timed_out = (cnt_q == CNT_W'(TIMEOUT));

  // Next-state and next-output logic; outputs are computed one cycle ahead
  // so that every port is driven straight from a flop.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    cnt_d       = cnt_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    done_d      = '0;
    p_d         = '0;
    err_d       = 1'b0;
    mul_start_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_d     = pick_grant;
          mul_a_d     = a_i[8*pick_grant +: 8];
          mul_b_d     = b_i[8*pick_grant +: 8];
          mul_start_d = 1'b1;
          state_d     = ST_START;
        end
      end
      ST_START: begin
        cnt_d   = '0;
        state_d = ST_WAIT_HI;
      end
      ST_WAIT_HI: begin
        if (mul_busy_i) begin
          cnt_d   = '0;
          state_d = ST_WAIT_LO;
        end else if (timed_out) begin
          done_d  = NREQ'(onehot4(grant_q));
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT_LO: begin
        if (!mul_busy_i) begin
          done_d  = NREQ'(onehot4(grant_q));
          p_d     = mul_p_i;
          state_d = ST_DONE;
        end else if (timed_out) begin
          done_d  = NREQ'(onehot4(grant_q));
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        ptr_d   = grant_q + 2'd1;
        mul_a_d = '0;
        mul_b_d = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value regardless of statement order.
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      grant_q     <= '0;
      cnt_q       <= '0;
      done_q      <= '0;
      p_q         <= '0;
      err_q       <= 1'b0;
      mul_start_q <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      p_q         <= p_d;
      err_q       <= err_d;
      mul_start_q <= mul_start_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
    end
  end

  assign done_o      = done_q;
  assign p_o         = p_q;
  assign err_o       = err_q;
  assign mul_start_o = mul_start_q;
  assign mul_a_o     = mul_a_q;
  assign mul_b_o     = mul_b_q;

endmodule

// File: tb/tb_mul8_arb.sv
// Scoreboard bench for mul8_arb with a behavioural mul8_loop stand-in.
module tb_mul8_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req_i = '0;
  logic [31:0] a_i = '0;
  logic [31:0] b_i = '0;
  logic [3:0]  done_o;
  logic [7:0]  p_o;
  logic        err_o;
  logic        mul_start_o;
  logic [7:0]  mul_a_o;
  logic [7:0]  mul_b_o;
  logic        mul_busy_i = 1'b0;
  logic [7:0]  mul_p_i = '0;

  mul8_arb dut (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req_i),
    .a_i         (a_i),
    .b_i         (b_i),
    .done_o      (done_o),
    .p_o         (p_o),
    .err_o       (err_o),
    .mul_start_o (mul_start_o),
    .mul_a_o     (mul_a_o),
    .mul_b_o     (mul_b_o),
    .mul_busy_i  (mul_busy_i),
    .mul_p_i     (mul_p_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] idx;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] p;
    logic       err;
    bit         tmo;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   mptr  = 0;     // model round-robin pointer
  bit   stuck = 1'b0;  // multiplier never raises busy
  int   lat_fixed = 0; // 0 = random busy duration

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural mul8_loop: busy for a few cycles after start, then p = (a*b)>>8.
  initial begin
    int   rem = 0;
    logic [7:0] pa, pb;
    forever begin
      @(negedge clk);
      if (rst) begin
        mul_busy_i = 1'b0;
        mul_p_i    = '0;
        rem        = 0;
      end else if (mul_busy_i) begin
        if (rem <= 1) begin
          mul_busy_i = 1'b0;
          mul_p_i    = 8'((16'(pa) * 16'(pb)) >> 8);
        end else begin
          rem--;
        end
      end else if (mul_start_o && !stuck) begin
        pa         = mul_a_o;
        pb         = mul_b_o;
        rem        = (lat_fixed != 0) ? lat_fixed : int'($urandom_range(2, 6));
        mul_busy_i = 1'b1;
      end
    end
  end

  // Monitor: compares every start and completion against the scoreboard.
  initial begin
    int  cyc = 0;
    int  start_cyc = 0;
    bit  prev_start = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        check("done_in_reset", 32'(done_o), 0);
        prev_start = 1'b0;
        continue;
      end
      if (mul_start_o) begin
        check("start_width", 32'(prev_start), 0);
        start_cyc = cyc;
        if (exp_q.size() == 0) check("unexpected_start", 1, 0);
        else begin
          check("start_a", 32'(mul_a_o), 32'(exp_q[0].a));
          check("start_b", 32'(mul_b_o), 32'(exp_q[0].b));
        end
      end
      prev_start = mul_start_o;
      if (done_o != 0) begin
        check("done_onehot", 32'($countones(done_o)), 1);
        if (exp_q.size() == 0) check("unexpected_done", 32'(done_o), 0);
        else begin
          e = exp_q.pop_front();
          check("done_idx", 32'(done_o), 32'(4'b0001 << e.idx));
          check("done_p", 32'(p_o), 32'(e.p));
          check("done_err", 32'(err_o), 32'(e.err));
          if (e.tmo) check("timeout_latency", 32'(cyc - start_cyc - 1), 32);
        end
      end else begin
        check("idle_p", 32'(p_o), 0);
        check("idle_err", 32'(err_o), 0);
      end
    end
  end

  // Raise requests and push the expected service order from the model pointer.
  task automatic issue(input logic [3:0] mask, input logic [31:0] a, input logic [31:0] b,
                       input bit tmo, output int n);
    logic [3:0] pend = mask;
    exp_t e;
    n = 0;
    a_i   = a;
    b_i   = b;
    req_i = req_i | mask;
    while (pend != 0) begin
      for (int off = 0; off < 4; off++) begin
        int k = (mptr + off) % 4;
        if (pend[k]) begin
          e.idx = 2'(k);
          e.a   = a[8*k +: 8];
          e.b   = b[8*k +: 8];
          e.err = tmo;
          e.tmo = tmo;
          e.p   = tmo ? 8'h00 : 8'((16'(e.a) * 16'(e.b)) >> 8);
          exp_q.push_back(e);
          pend[k] = 1'b0;
          mptr = (k + 1) % 4;
          n++;
          break;
        end
      end
    end
  endtask

  // Run until n completions, retiring each requester when its done is seen.
  task automatic drain(input int n, input int budget);
    int seen = 0;
    int c = 0;
    while (seen < n && c < budget) begin
      @(negedge clk);
      c++;
      if (done_o != 0) begin
        seen++;
        req_i = req_i & ~done_o;
      end
    end
    if (seen < n) begin
      check("drain_timeout", 32'(seen), 32'(n));
      exp_q.delete();
      req_i = '0;
    end
    @(negedge clk);
  endtask

  task automatic wait_busy(input int budget);
    int c = 0;
    while (!mul_busy_i && c < budget) begin
      @(negedge clk);
      c++;
    end
    if (!mul_busy_i) check("busy_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    #1 rst = 1'b1;
    #1;
    check("rst_done", 32'(done_o), 0);
    check("rst_p", 32'(p_o), 0);
    check("rst_err", 32'(err_o), 0);
    check("rst_start", 32'(mul_start_o), 0);
    check("rst_mul_a", 32'(mul_a_o), 0);
    check("rst_mul_b", 32'(mul_b_o), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // All four at once from reset: served 0,1,2,3.
    issue(4'b1111, 32'h9C_37_E1_52, 32'hA5_C8_1F_B3, 1'b0, n);
    drain(n, 200);

    // Single request 0x45 x 0x55 -> 0x16.
    issue(4'b0001, 32'h0000_0045, 32'h0000_0055, 1'b0, n);
    drain(n, 60);

    // Rotation: serve requester 1, then 0101 must go to 2 before 0.
    issue(4'b0010, 32'h0000_7700, 32'h0000_8800, 1'b0, n);
    drain(n, 60);
    issue(4'b0101, 32'h0011_0022, 32'h0033_0044, 1'b0, n);
    drain(n, 120);

    // Stuck multiplier: timeout with err and p=0.
    stuck = 1'b1;
    issue(4'b0100, 32'h0012_0000, 32'h0034_0000, 1'b1, n);
    drain(n, 80);
    stuck = 1'b0;

    // 0xFF x 0xFF with req dropped during WAIT_LO.
    lat_fixed = 6;
    issue(4'b0001, 32'h0000_00FF, 32'h0000_00FF, 1'b0, n);
    wait_busy(10);
    @(negedge clk);
    @(negedge clk);
    req_i[0] = 1'b0;
    drain(n, 60);

    // Reset during WAIT_LO after requester 1 moved the pointer to 2.
    issue(4'b0010, 32'h0000_3300, 32'h0000_4400, 1'b0, n);
    drain(n, 60);
    lat_fixed = 8;
    issue(4'b0001, 32'h0000_00C3, 32'h0000_005A, 1'b0, n);
    wait_busy(10);
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_mul_a", 32'(mul_a_o), 32'h0000_00C3);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_done", 32'(done_o), 0);
    check("mid_rst_p", 32'(p_o), 0);
    check("mid_rst_err", 32'(err_o), 0);
    check("mid_rst_start", 32'(mul_start_o), 0);
    check("mid_rst_mul_a", 32'(mul_a_o), 0);
    check("mid_rst_mul_b", 32'(mul_b_o), 0);
    exp_q.delete();
    req_i = '0;
    mptr  = 0;
    lat_fixed = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue(4'b1010, 32'hD0_00_B0_00, 32'hE0_00_C0_00, 1'b0, n);
    drain(n, 120);
    issue(4'b1000, 32'h8F_00_00_00, 32'h71_00_00_00, 1'b0, n);
    drain(n, 60);

    // Randomized batches.
    for (int t = 0; t < 25; t++) begin
      issue(4'($urandom_range(1, 15)), $urandom, $urandom, 1'b0, n);
      drain(n, 240);
    end

    check("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mul8_arb.md
MUL8_ARB -- requirements
Module: mul8_arb

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing one mul8_loop multiplier; fixed at 4 in this revision.
REQ-002 Parameter TIMEOUT, default 31, maximum cycles spent waiting on mul_busy_i in any single wait state.
REQ-003 Port clk  input  1  single system clock, rising edge.
REQ-004 Port rst  input  1  asynchronous, active-high reset.
REQ-005 Port req_i  input  4  per-requester request level; held high with operands stable until that requester's done_o.
REQ-006 Port a_i  input  32  operand A, byte k belongs to requester k.
REQ-007 Port b_i  input  32  operand B, byte k belongs to requester k.
REQ-008 Port done_o  output  4  one-hot, one-cycle completion pulse to the served requester.
REQ-009 Port p_o  output  8  result byte, valid while any done_o bit is high.
REQ-010 Port err_o  output  1  one-cycle pulse coincident with done_o when the operation timed out.
REQ-011 Port mul_start_o / mul_a_o / mul_b_o  output  1/8/8  drive mul8_loop start, a_i and b_i.
REQ-012 Port mul_busy_i / mul_p_i  input  1/8  from mul8_loop busy and p_o, where p_o is the upper byte of a*b.

Function
REQ-013 The FSM states SHALL be IDLE, START, WAIT_HI, WAIT_LO and DONE.
REQ-014 In IDLE, any req_i bit high selects a grant index round-robin from pointer ptr, checking ptr, ptr+1, ... modulo 4; the grant index and its operand bytes are registered, then next state is START.
REQ-015 In START, mul_start_o is high for exactly one cycle and mul_a_o/mul_b_o carry the latched operands; next state is WAIT_HI.
REQ-016 mul_a_o/mul_b_o hold the latched operands from START until DONE and are 0 otherwise.
REQ-017 WAIT_HI waits for mul_busy_i=1, then goes to WAIT_LO; WAIT_LO waits for mul_busy_i=0, then captures mul_p_i into p_o and goes to DONE.
REQ-018 A 5-bit wait counter clears on entry to WAIT_HI and WAIT_LO; on reaching TIMEOUT it forces DONE with p_o=0 and err_o=1.
REQ-019 In DONE, done_o[grant]=1 for one cycle, ptr becomes grant+1 modulo 4, and next state is IDLE; p_o returns to 0 after DONE.
REQ-020 Minimum latency from req_i sampled in IDLE to done_o is 4 cycles plus the multiplier busy duration.
REQ-021 Requester contract: the requester deasserts req_i on the clock edge that samples done_o, so a repeated request is re-arbitrated fairly.
REQ-022 req_i dropping mid-operation SHALL NOT abort the operation; done_o is still pulsed.
REQ-023 Simultaneous requests SHALL be served one per operation in round-robin order; no requester is starved beyond 3 intervening operations.
REQ-024 At most one done_o bit is high in any cycle, and mul_start_o is never high outside START.

Reset
REQ-025 rst SHALL asynchronously force state=IDLE, ptr=0, grant=0, counter=0, and done_o, err_o, p_o, mul_start_o, mul_a_o, mul_b_o all 0.
REQ-026 Reset mid-operation abandons the operation with no done_o; the first post-reset arbitration starts at requester 0.

Structure
REQ-027 State encodings, NREQ and TIMEOUT defaults SHALL live in a shared package or include, mul8_pkg.
REQ-028 Round-robin selection SHALL be one sub-module, rr_pick4: inputs req[3:0] and ptr[1:0]; outputs grant index and valid.
REQ-029 mul8_arb SHALL NOT instantiate mul8_loop; the top level connects the two.

Verification
REQ-030 Single request: req_i[0]=1, a=0x45, b=0x55 -> one mul_start_o pulse, then done_o=0001 with p_o=0x16 and err_o=0.
REQ-031 All four requests from reset: req_i=1111, distinct operands -> done_o order 0001, 0010, 0100, 1000, each p_o equal to (a*b)>>8 for that requester.
REQ-032 Rotation: after requester 1 is served and req_i=0101 -> requester 2 is granted before requester 0.
REQ-033 Stuck multiplier: mul_busy_i held 0 after start -> done_o pulse 32 cycles after WAIT_HI entry, with err_o=1 and p_o=0.
REQ-034 Reset asserted during WAIT_LO -> all outputs 0 immediately, no done_o; the next req_i=1000 is served normally.
REQ-035 Operands 0xFF x 0xFF -> p_o=0xFE; and req_i dropped during WAIT_LO -> done_o still pulses.
